// File: rtl/qpu_event_trigger_pkg.sv
// Shared definitions for the QPU event trigger receiver.
// Holds the default channel count and field widths, the bit offsets of the
// timestamp and payload inside one event word, and the per-channel
// scheduler state type.
package qpu_event_trigger_pkg;

  localparam int QPU_EVENT_NUM     = 4;
  localparam int QPU_TIME_WIDTH    = 32;
  localparam int QPU_PAYLOAD_WIDTH = 16;
  localparam int QPU_EVENT_WIDTH   = QPU_TIME_WIDTH + QPU_PAYLOAD_WIDTH;

  // An event word is {timestamp, payload}; the payload sits in the low bits.
  localparam int QPU_PAYLOAD_LSB   = 0;
  localparam int QPU_TS_LSB        = QPU_PAYLOAD_WIDTH;

  typedef enum logic {
    CH_IDLE  = 1'b0,
    CH_ARMED = 1'b1
  } ch_state_e;

endpackage

// File: rtl/qpu_event_trigger_fifo.sv
// qpu_event_fifo: single-clock FIFO holding timestamped events for one channel.
// Ports:
//   clk, rst    clock and synchronous active-high reset (clears pointers)
//   push_i      write wdata_i; ignored when full unless a pop happens too
//   pop_i       drop the head entry; ignored when empty
//   wdata_i     event word to write
//   head_o      current head entry (valid when empty_o=0)
//   full_o      all DEPTH entries occupied
//   empty_o     no entries
//   last_o      exactly one entry left
module qpu_event_fifo
  import qpu_event_trigger_pkg::*;
#(
  parameter int WIDTH = QPU_EVENT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        push_ok, pop_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign last_o  = (count == (AW+1)'(1));
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers decide what is readable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/qpu_event_trigger.sv
// qpu_event_trigger: timing-side receiver of the EXU trigger interface.
// Owns the timeline counter, buffers timestamped events per channel and
// issues each one when the timeline reaches its timestamp.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   trigger_i_clk_ena    timeline advance enable
//   trigger_o_clk        timeline value, fed back to the EXU
//   trigger_i_valid      per-channel push strobe
//   trigger_i_data       per-channel {timestamp, payload}, channel k in slice k
//   event_o_valid        one-cycle issue pulse per channel
//   event_o_payload      issued payload per channel
//   fifo_o_full          per-channel FIFO full status
//   err_o_overflow       sticky: push dropped on a full channel
//   err_o_late           sticky: event issued after its timestamp
//   err_i_clr            clears both sticky error vectors
//
// Per-channel scheduler:
//   state    | meaning
//   CH_IDLE  | channel FIFO empty, nothing to compare
//   CH_ARMED | head entry present, compared against the timeline every cycle
module qpu_event_trigger
  import qpu_event_trigger_pkg::*;
#(
  parameter int EVENT_NUM  = QPU_EVENT_NUM,
  parameter int TIME_W     = QPU_TIME_WIDTH,
  parameter int PAYLOAD_W  = QPU_PAYLOAD_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  trigger_i_clk_ena,
  output logic [TIME_W-1:0]                     trigger_o_clk,
  input  logic [EVENT_NUM-1:0]                  trigger_i_valid,
  input  logic [EVENT_NUM*(TIME_W+PAYLOAD_W)-1:0] trigger_i_data,
  output logic [EVENT_NUM-1:0]                  event_o_valid,
  output logic [EVENT_NUM*PAYLOAD_W-1:0]        event_o_payload,
  output logic [EVENT_NUM-1:0]                  fifo_o_full,
  output logic [EVENT_NUM-1:0]                  err_o_overflow,
  output logic [EVENT_NUM-1:0]                  err_o_late,
  input  logic                                  err_i_clr
);

  localparam int EW = TIME_W + PAYLOAD_W;

  logic [TIME_W-1:0]                 time_q, time_d;
  ch_state_e [EVENT_NUM-1:0]         state_q, state_d;
  logic [EVENT_NUM-1:0]              ev_valid_q, ev_valid_d;
  logic [EVENT_NUM*PAYLOAD_W-1:0]    ev_payload_q, ev_payload_d;
  logic [EVENT_NUM-1:0]              ovf_q, ovf_d;
  logic [EVENT_NUM-1:0]              late_q, late_d;

  logic [EVENT_NUM-1:0][EW-1:0]      fifo_head;
  logic [EVENT_NUM-1:0][PAYLOAD_W-1:0] head_payload;
  logic [EVENT_NUM-1:0]              fifo_full, fifo_empty, fifo_last, fifo_push;
  logic [EVENT_NUM-1:0]              ch_due, ch_late, ch_drop;

  for (genvar gk = 0; gk < EVENT_NUM; gk++) begin : g_ch
    logic [TIME_W-1:0] head_ts;
    logic [TIME_W-1:0] delta;
    logic              armed;

    assign head_ts = fifo_head[gk][PAYLOAD_W +: TIME_W];
    assign head_payload[gk] = fifo_head[gk][PAYLOAD_W-1:0];
    assign armed = (state_q[gk] == CH_ARMED) && !fifo_empty[gk];

    // Modular distance to the head timestamp; a set MSB means it is already
    // behind the timeline (or too far ahead to be distinguished from that).
    assign delta       = head_ts - time_q;
    assign ch_late[gk] = armed && delta[TIME_W-1];
    assign ch_due[gk]  = armed && ((delta == '0) || delta[TIME_W-1]);

    assign fifo_push[gk] = trigger_i_valid[gk] && (!fifo_full[gk] || ch_due[gk]);
    assign ch_drop[gk]   = trigger_i_valid[gk] && fifo_full[gk] && !ch_due[gk];

    qpu_event_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[gk]),
      .pop_i   (ch_due[gk]),
      .wdata_i (trigger_i_data[gk*EW +: EW]),
      .head_o  (fifo_head[gk]),
      .full_o  (fifo_full[gk]),
      .empty_o (fifo_empty[gk]),
      .last_o  (fifo_last[gk])
    );
  end

  always_comb begin
    time_d       = trigger_i_clk_ena ? time_q + TIME_W'(1) : time_q;
    state_d      = state_q;
    ev_valid_d   = ch_due;
    ev_payload_d = '0;
    for (int k = 0; k < EVENT_NUM; k++) begin
      if (ch_due[k]) ev_payload_d[k*PAYLOAD_W +: PAYLOAD_W] = head_payload[k];
      case (state_q[k])
        // A push into an empty FIFO is only compared from the next cycle on.
        CH_IDLE:  if (fifo_push[k]) state_d[k] = CH_ARMED;
        CH_ARMED: if (ch_due[k] && fifo_last[k] && !fifo_push[k]) state_d[k] = CH_IDLE;
        default:  state_d[k] = CH_IDLE;
      endcase
    end
    // A new error in the clearing cycle still sets its bit.
    ovf_d  = (ovf_q  & ~{EVENT_NUM{err_i_clr}}) | ch_drop;
    late_d = (late_q & ~{EVENT_NUM{err_i_clr}}) | ch_late;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q       <= '0;
      state_q      <= {EVENT_NUM{CH_IDLE}};
      ev_valid_q   <= '0;
      ev_payload_q <= '0;
      ovf_q        <= '0;
      late_q       <= '0;
    end else begin
      time_q       <= time_d;
      state_q      <= state_d;
      ev_valid_q   <= ev_valid_d;
      ev_payload_q <= ev_payload_d;
      ovf_q        <= ovf_d;
      late_q       <= late_d;
    end
  end

  assign trigger_o_clk   = time_q;
  assign event_o_valid   = ev_valid_q;
  assign event_o_payload = ev_payload_q;
  assign fifo_o_full     = fifo_full;
  assign err_o_overflow  = ovf_q;
  assign err_o_late      = late_q;

endmodule

// File: tb/tb_qpu_event_trigger.sv
// Bench for qpu_event_trigger. The timeline is narrowed to 12 bits so the
// wrap-around case is reachable in a few thousand cycles.
module tb_qpu_event_trigger;

  localparam int EN = 4;
  localparam int TW = 12;
  localparam int PW = 16;
  localparam int FD = 4;
  localparam int EW = TW + PW;
  localparam int unsigned TMOD = 1 << TW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                trigger_i_clk_ena = 1'b0;
  logic [TW-1:0]       trigger_o_clk;
  logic [EN-1:0]       trigger_i_valid = '0;
  logic [EN*EW-1:0]    trigger_i_data = '0;
  logic [EN-1:0]       event_o_valid;
  logic [EN*PW-1:0]    event_o_payload;
  logic [EN-1:0]       fifo_o_full;
  logic [EN-1:0]       err_o_overflow;
  logic [EN-1:0]       err_o_late;
  logic                err_i_clr = 1'b0;

  qpu_event_trigger #(
    .EVENT_NUM  (EN),
    .TIME_W     (TW),
    .PAYLOAD_W  (PW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .trigger_i_clk_ena (trigger_i_clk_ena),
    .trigger_o_clk     (trigger_o_clk),
    .trigger_i_valid   (trigger_i_valid),
    .trigger_i_data    (trigger_i_data),
    .event_o_valid     (event_o_valid),
    .event_o_payload   (event_o_payload),
    .fifo_o_full       (fifo_o_full),
    .err_o_overflow    (err_o_overflow),
    .err_o_late        (err_o_late),
    .err_i_clr         (err_i_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue per channel, compared against the timeline.
  int unsigned   m_time;
  logic [EW-1:0] m_q [EN][$];
  logic [EN-1:0] m_valid, m_late, m_ovf, m_full;
  logic [EN*PW-1:0] m_pay;

  int          issue_cnt [EN];
  int unsigned last_issue_t [EN];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [EW-1:0] h;
    int unsigned   ts, d;
    logic [EN-1:0] nlate, novf;
    nlate = '0;
    novf  = '0;
    if (rst) begin
      m_time  = 0;
      for (int k = 0; k < EN; k++) m_q[k].delete();
      m_valid = '0;
      m_pay   = '0;
      m_late  = '0;
      m_ovf   = '0;
      m_full  = '0;
      return;
    end
    m_valid = '0;
    m_pay   = '0;
    for (int k = 0; k < EN; k++) begin
      // Heads present before this cycle are compared; a new push is not.
      if (m_q[k].size() > 0) begin
        h  = m_q[k][0];
        ts = int'(h[EW-1 -: TW]);
        d  = (ts + TMOD - m_time) % TMOD;
        if (d == 0 || d >= TMOD / 2) begin
          m_valid[k] = 1'b1;
          m_pay[k*PW +: PW] = h[PW-1:0];
          if (d != 0) nlate[k] = 1'b1;
          void'(m_q[k].pop_front());
        end
      end
      if (trigger_i_valid[k]) begin
        if (m_q[k].size() < FD) m_q[k].push_back(trigger_i_data[k*EW +: EW]);
        else novf[k] = 1'b1;
      end
      m_full[k] = (m_q[k].size() == FD);
    end
    m_late = (m_late & ~{EN{err_i_clr}}) | nlate;
    m_ovf  = (m_ovf  & ~{EN{err_i_clr}}) | novf;
    if (trigger_i_clk_ena) m_time = (m_time + 1) % TMOD;
  endtask

  task automatic compare_all();
    check_eq("timeline", 64'(trigger_o_clk), 64'(m_time));
    check_eq("ev_valid", 64'(event_o_valid), 64'(m_valid));
    for (int k = 0; k < EN; k++)
      if (m_valid[k])
        check_eq($sformatf("payload%0d", k), 64'(event_o_payload[k*PW +: PW]), 64'(m_pay[k*PW +: PW]));
    check_eq("err_late", 64'(err_o_late), 64'(m_late));
    check_eq("err_ovf", 64'(err_o_overflow), 64'(m_ovf));
    check_eq("fifo_full", 64'(fifo_o_full), 64'(m_full));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    for (int k = 0; k < EN; k++)
      if (event_o_valid[k]) begin
        issue_cnt[k]++;
        last_issue_t[k] = m_time;
      end
    trigger_i_valid = '0;
    err_i_clr = 1'b0;
  endtask

  task automatic set_push(input int k, input int unsigned ts, input logic [PW-1:0] pl);
    trigger_i_valid[k] = 1'b1;
    trigger_i_data[k*EW +: EW] = {ts[TW-1:0], pl};
  endtask

  task automatic run_to(input int unsigned t);
    for (int i = 0; i < int'(TMOD) + 8 && m_time != t; i++) tick();
    check_eq("run_to", 64'(trigger_o_clk), 64'(t));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base [EN];
    for (int k = 0; k < EN; k++) begin
      issue_cnt[k] = 0;
      last_issue_t[k] = 0;
    end

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_clk", 64'(trigger_o_clk), 64'd0);
    check_eq("rst_valid", 64'(event_o_valid), 64'd0);
    check_eq("rst_payload", 64'(event_o_payload), 64'd0);
    check_eq("rst_err", 64'({err_o_late, err_o_overflow}), 64'd0);

    // 1: on-time issue
    trigger_i_clk_ena = 1'b1;
    tick();
    tick();
    base[0] = issue_cnt[0];
    set_push(0, 10, 16'h00A5);
    tick();
    run_to(14);
    check_eq("t1_issues", 64'(issue_cnt[0] - base[0]), 64'd1);
    check_eq("t1_time", 64'(last_issue_t[0]), 64'd11);
    check_eq("t1_late", 64'(err_o_late), 64'd0);

    // 2: late event, then clear
    run_to(20);
    set_push(1, 15, 16'h1234);
    tick();
    tick();
    check_eq("t2_valid", 64'(event_o_valid[1]), 64'd1);
    check_eq("t2_late", 64'(err_o_late[1]), 64'd1);
    err_i_clr = 1'b1;
    tick();
    check_eq("t2_clr", 64'(err_o_late), 64'd0);

    // 3: overflow with a frozen timeline
    trigger_i_clk_ena = 1'b0;
    do_reset();
    base[2] = issue_cnt[2];
    for (int i = 0; i < 5; i++) begin
      set_push(2, 100, 16'(16'h0200 + i));
      tick();
    end
    check_eq("t3_full", 64'(fifo_o_full[2]), 64'd1);
    check_eq("t3_ovf", 64'(err_o_overflow[2]), 64'd1);
    trigger_i_clk_ena = 1'b1;
    run_to(110);
    check_eq("t3_issues", 64'(issue_cnt[2] - base[2]), 64'd4);
    check_eq("t3_last", 64'(last_issue_t[2]), 64'd104);
    check_eq("t3_late", 64'(err_o_late[2]), 64'd1);

    // 4: all channels in parallel
    do_reset();
    run_to(40);
    for (int k = 0; k < EN; k++) begin
      base[k] = issue_cnt[k];
      set_push(k, 50, 16'(16'h1111 * (k + 1)));
    end
    tick();
    run_to(55);
    for (int k = 0; k < EN; k++) begin
      check_eq($sformatf("t4_cnt%0d", k), 64'(issue_cnt[k] - base[k]), 64'd1);
      check_eq($sformatf("t4_time%0d", k), 64'(last_issue_t[k]), 64'd51);
    end

    // 5: wrap-around
    err_i_clr = 1'b1;
    tick();
    run_to(TMOD - 2);
    base[3] = issue_cnt[3];
    set_push(3, 1, 16'hBEEF);
    tick();
    run_to(5);
    check_eq("t5_cnt", 64'(issue_cnt[3] - base[3]), 64'd1);
    check_eq("t5_time", 64'(last_issue_t[3]), 64'd2);
    check_eq("t5_late", 64'(err_o_late[3]), 64'd0);

    // 6: reset with events queued
    for (int k = 0; k < 3; k++) set_push(k, (m_time + 20) % TMOD, 16'(16'hC000 + k));
    tick();
    tick();
    for (int k = 0; k < EN; k++) base[k] = issue_cnt[k];
    do_reset();
    for (int i = 0; i < 40; i++) tick();
    for (int k = 0; k < EN; k++)
      check_eq($sformatf("t6_cnt%0d", k), 64'(issue_cnt[k] - base[k]), 64'd0);
    check_eq("t6_clk", 64'(trigger_o_clk), 64'd40);
    check_eq("t6_err", 64'({err_o_late, err_o_overflow}), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(399) == 0);
      trigger_i_clk_ena = ($urandom_range(3) != 0);
      err_i_clr = ($urandom_range(31) == 0);
      for (int k = 0; k < EN; k++)
        if ($urandom_range(4) == 0)
          set_push(k, (m_time + TMOD - 3 + $urandom_range(15)) % TMOD, 16'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qpu_event_trigger.md
Name: qpu_event_trigger

Overview:
- Timing-side receiver for the EXU trigger interface.
- Owns the quantum timeline counter that is fed back to the EXU as its time input.
- Accepts timestamped events from the EXU on up to EVENT_NUM channels and buffers each channel in its own FIFO.
- Releases each event to the downstream pulse/measurement drivers exactly when the timeline reaches the event's timestamp.

Parameters:
- EVENT_NUM, 4, number of independent event channels (matches the EXU event count)
- TIME_W, 32, width of the timeline counter and of each timestamp
- PAYLOAD_W, 16, width of the per-event payload (gate/operation code plus qubit mask)
- FIFO_DEPTH, 4, entries per channel FIFO; must be a power of 2 and at least 2

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous reset, active-high
- trigger_i_clk_ena  in  1  timeline advance enable, driven from the EXU clk-ena output
- trigger_o_clk  out  TIME_W  current timeline value, fed to the EXU time input
- trigger_i_valid  in  EVENT_NUM  per-channel event push strobe from the EXU
- trigger_i_data  in  EVENT_NUM*(TIME_W+PAYLOAD_W)  per-channel {timestamp, payload}; channel k occupies slice k
- event_o_valid  out  EVENT_NUM  one-cycle issue pulse per channel
- event_o_payload  out  EVENT_NUM*PAYLOAD_W  payload of the issued event, valid only with event_o_valid
- fifo_o_full  out  EVENT_NUM  per-channel full status, observation only
- err_o_overflow  out  EVENT_NUM  sticky: a push was dropped on this channel
- err_o_late  out  EVENT_NUM  sticky: an event issued after its timestamp
- err_i_clr  in  1  clears both sticky error vectors

Behaviour:
- Reset: all of the following are 0 on the cycle after rst=1:
  - trigger_o_clk
  - event_o_valid, event_o_payload
  - all FIFO pointers and counts
  - err_o_overflow, err_o_late
- rst has priority over every other input.
- Timeline counter:
  - Increments by 1 on each clk edge where trigger_i_clk_ena=1; holds otherwise.
  - Wraps modulo 2^TIME_W: 2^TIME_W-1 goes to 0 with no flag.
- Push:
  - trigger_i_valid[k]=1 writes slice k into FIFO k.
  - There is no backpressure; the EXU has no ready signal.
  - If FIFO k is full and is not popping in the same cycle, the push is dropped and err_o_overflow[k] is set.
  - If FIFO k is full and pops in the same cycle, the push is accepted.
- Per-channel scheduler (one independent IDLE/ARMED FSM per channel):
  - IDLE: FIFO empty. A push moves the FSM to ARMED on the next cycle; the write is not visible to the comparison in the same cycle.
  - ARMED: each cycle compute d = head.ts - trigger_o_clk in modular TIME_W arithmetic.
  - If d == 0: the head is due. Pop it, and on the next cycle drive event_o_valid[k]=1 and event_o_payload slice k = head.payload.
  - If d[TIME_W-1] == 1 (negative): the head is late. Pop and issue as above, and set err_o_late[k].
  - Otherwise: wait.
  - After a pop, return to IDLE if the FIFO becomes empty, else stay ARMED.
  - At most one issue per channel per cycle. Several heads with equal timestamps drain on consecutive cycles; the second and later ones are flagged late only if the counter has advanced.
- Latency: an event whose timestamp equals the counter value in cycle N appears on event_o_* in cycle N+1.
- Clock stall: with clk_ena=0 the counter is frozen. A head with ts == counter still issues once. Later heads with the same ts issue on following cycles without a late flag.
- Wrap window: events are valid only if ts - now < 2^(TIME_W-1). Anything further ahead is treated as late by design.
- Channels are fully independent; simultaneous events on different channels issue in the same cycle.
- err_i_clr: clears the sticky bits. If err_i_clr and a new error occur in the same cycle, the new error wins and the bit is set.
- Reset mid-operation: all queued events are discarded and nothing issues after reset.

Decomposition:
- Add the following to QPU_defines.v as `define constants:
  - QPU_EVENT_NUM
  - QPU_TIME_WIDTH
  - event payload width
  - timestamp/payload slice offsets
- Sub-module qpu_event_fifo:
  - Synchronous FIFO of width TIME_W+PAYLOAD_W and depth FIFO_DEPTH.
  - Pointers of log2(FIFO_DEPTH)+1 bits for full/empty detection.
  - Exposes head data, full, empty, push, pop.
  - Instantiated EVENT_NUM times by a generate loop.
- The top block holds the counter, the per-channel FSMs, the output registers and the error flags.

Test Plan:
1. On-time issue: rst, then clk_ena=1; push ch0 {ts=10, payload=0x00A5} at counter 2 -> event_o_valid[0] pulses for exactly one cycle, one cycle after trigger_o_clk==10, payload 0x00A5; err_o_late=0.
2. Late event: at counter 20, push ch1 {ts=15, payload=0x1234} -> issues 2 cycles after the push, err_o_late[1]=1; err_i_clr -> err_o_late=0.
3. Overflow: clk_ena=0 at counter 0; push 5 events with ts=100 to ch2 -> fifo_o_full[2]=1, 5th push dropped, err_o_overflow[2]=1; clk_ena=1 -> exactly 4 issues, on cycles 101, 102, 103, 104 relative to counter, the last three flagged late.
4. Parallel channels: push all 4 channels with ts=50 and distinct payloads in the same cycle -> event_o_valid=4'b1111 in a single cycle with the correct payload slices.
5. Wrap-around: force the counter to 0xFFFFFFFE by running cycles; push {ts=1} -> no late flag, issues after the counter wraps to 1.
6. Reset mid-run: 3 events queued, rst pulsed -> no issues afterwards, counter=0, all flags 0.
